// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO bus responder behind the CPU memory handshake.
// Decodes word RAM versus memory-mapped IO (switches, LEDs, cycle counter),
// inserts WAIT_CYCLES wait states and answers each request with a one-cycle
// MIO_ready strobe. A request with both MemRead and MemWrite set is performed
// as a write and flagged on bus_err in its ACK cycle.
// Optional feature macro: MIO_COUNTER_EN builds the free-running cycle
// counter readable at 0xF0000004; without it that address reads as zero.
module mio_bus_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;
  localparam logic [31:0] LED_ADDR  = 32'hE000_0000;

  state_t              state;
  state_t              state_next;
  logic [3:0]          wait_cnt;
  logic [3:0]          wait_cnt_next;

  logic                req;

  // Transaction captured in IDLE; WAIT and ACK work only from these copies.
  logic [31:2]         lat_addr;
  logic [31:0]         lat_data;
  logic                lat_write;
  logic                lat_both;

  // Address/op of the transaction about to enter ACK. When WAIT_CYCLES is 0
  // the ACK entry happens from IDLE, before the latches hold the request.
  logic [31:2]         cur_addr;
  logic [31:0]         cur_full;
  logic                cur_write;
  logic                cur_is_ram;
  logic [ADDR_W-1:0]   cur_idx;
  logic [31:0]         io_rdata;

  logic [31:0]         lat_full;
  logic                lat_is_ram;
  logic                lat_is_led;
  logic [ADDR_W-1:0]   lat_idx;

  logic [31:0]         cycle_val;
  logic [31:0]         ram [2**ADDR_W];

  logic                unused_addr_lsbs;

  assign req              = CPU_MIO & (MemRead | MemWrite);
  assign unused_addr_lsbs = ^addr_bus[1:0];

`ifdef MIO_COUNTER_EN
  logic [31:0] cycle_cnt;

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  // Select live request in IDLE, latched request otherwise.
  always_comb begin
    cur_addr  = lat_addr;
    cur_write = lat_write;
    if (state == S_IDLE) begin
      cur_addr  = addr_bus[31:2];
      cur_write = MemWrite;
    end
    cur_full = {cur_addr, 2'b00};
    cur_idx  = cur_addr[ADDR_W+1:2];
  end

  // Read-side address decode; top nibble E/F is IO space, everything else RAM.
  always_comb begin
    io_rdata   = '0;
    cur_is_ram = 1'b0;
    if (cur_full == SW_ADDR) begin
      io_rdata = {16'h0000, sw_in};
    end else if (cur_full == CNT_ADDR) begin
      io_rdata = cycle_val;
    end else if (cur_full == LED_ADDR) begin
      io_rdata = {16'h0000, led_out};
    end else if (cur_addr[31:29] == 3'b111) begin
      io_rdata = '0;
    end else begin
      cur_is_ram = 1'b1;
    end
  end

  // Write-side decode from the latched address, used on the edge ending ACK.
  always_comb begin
    lat_full   = {lat_addr, 2'b00};
    lat_is_led = (lat_full == LED_ADDR);
    lat_is_ram = (lat_addr[31:29] != 3'b111);
    lat_idx    = lat_addr[ADDR_W+1:2];
  end

  // Next-state, wait counter and strobe outputs.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    MIO_ready     = 1'b0;
    bus_err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          wait_cnt_next = WAIT_INIT;
          state_next    = HAS_WAIT ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next = S_ACK;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      S_ACK: begin
        MIO_ready  = 1'b1;
        bus_err    = lat_both;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, request latches, read data register and LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      lat_both  <= 1'b0;
      Data_in   <= '0;
      led_out   <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == S_IDLE && req) begin
        lat_addr  <= addr_bus[31:2];
        lat_data  <= Data_out;
        lat_write <= MemWrite;
        lat_both  <= MemRead & MemWrite;
      end
      if (state_next == S_ACK && !cur_write) begin
        Data_in <= cur_is_ram ? ram[cur_idx] : io_rdata;
      end
      if (state == S_ACK && lat_write && lat_is_led) begin
        led_out <= lat_data[15:0];
      end
    end
  end

  // Word RAM write on the edge ending ACK; a reset in that cycle cancels it.
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACK && lat_write && lat_is_ram) begin
      ram[lat_idx] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: two responders (WAIT_CYCLES 2 and 0) driven with
// directed and random transactions and checked every cycle against a
// transaction-level model of the bus.
module tb_mio_bus_responder;

`ifdef MIO_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_mio   [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic        mio_ready [2];
  logic        bus_err   [2];
  logic [31:0] addr_bus  [2];
  logic [31:0] data_out  [2];
  logic [31:0] data_in   [2];
  logic [15:0] sw_in     [2];
  logic [15:0] led_out   [2];

  always #5 clk = ~clk;

  mio_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst), .CPU_MIO(cpu_mio[0]), .MemRead(mem_read[0]),
    .MemWrite(mem_write[0]), .addr_bus(addr_bus[0]), .Data_out(data_out[0]),
    .Data_in(data_in[0]), .MIO_ready(mio_ready[0]), .sw_in(sw_in[0]),
    .led_out(led_out[0]), .bus_err(bus_err[0])
  );

  mio_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(rst), .CPU_MIO(cpu_mio[1]), .MemRead(mem_read[1]),
    .MemWrite(mem_write[1]), .addr_bus(addr_bus[1]), .Data_out(data_out[1]),
    .Data_in(data_in[1]), .MIO_ready(mio_ready[1]), .sw_in(sw_in[1]),
    .led_out(led_out[1]), .bus_err(bus_err[1])
  );

  // Cycle index, sampled reset and the counter value the spec implies.
  int          cyc      = 0;
  logic        rst_q    = 1'b1;
  logic [31:0] cnt_m    = '0;
  logic [31:0] cnt_prev = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_q    <= rst;
    cnt_prev <= cnt_m;
    if (rst) cnt_m <= '0;
    else     cnt_m <= cnt_m + 32'd1;
  end

  // Model state
  logic [31:0] ram_m  [2][1024];
  bit          known  [2][1024];
  logic [31:0] data_m [2];
  logic [15:0] led_m  [2];
  int          issued [2];
  int          done   [2];
  int          due    [2];
  int          issue_cyc [2];
  int          last_rdy  [2];
  int          rdy_cnt   [2];
  int          err_cnt   [2];
  logic        t_rd   [2];
  logic        t_wr   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_data [2];
  logic [15:0] t_sw   [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int wcyc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return (a[31:28] == 4'hE) || (a[31:28] == 4'hF);
  endfunction

  function automatic logic [31:0] model_read(input int i);
    logic [31:0] a;
    a = t_addr[i] & ~32'd3;
    if (a == 32'hF000_0000) return {16'h0, t_sw[i]};
    if (a == 32'hF000_0004) return CNT_EN ? cnt_prev : 32'h0;
    if (a == 32'hE000_0000) return {16'h0, led_m[i]};
    if (is_io(a)) return 32'h0;
    return ram_m[i][widx(a)];
  endfunction

  task automatic model_write(input int i);
    logic [31:0] a;
    a = t_addr[i] & ~32'd3;
    if (a == 32'hE000_0000) begin
      led_m[i] = t_data[i][15:0];
    end else if (!is_io(a)) begin
      ram_m[i][widx(a)] = t_data[i];
      known[i][widx(a)] = 1'b1;
    end
  endtask

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    for (int i = 0; i < 2; i++) begin
      logic exp_rdy;
      logic exp_err;
      if (rst_q) begin
        done[i]   = issued[i];
        data_m[i] = '0;
        led_m[i]  = '0;
      end
      exp_rdy = (issued[i] != done[i]) && (cyc == due[i]);
      exp_err = exp_rdy && t_rd[i] && t_wr[i];
      if (exp_rdy && !t_wr[i]) data_m[i] = model_read(i);
      check("mio_ready", i, {31'b0, mio_ready[i]}, {31'b0, exp_rdy});
      check("bus_err",   i, {31'b0, bus_err[i]},   {31'b0, exp_err});
      check("data_in",   i, data_in[i], data_m[i]);
      check("led_out",   i, {16'h0, led_out[i]}, {16'h0, led_m[i]});
      if (exp_rdy) begin
        if (t_wr[i]) model_write(i);
        done[i] = issued[i];
      end
      if (mio_ready[i] === 1'b1) begin
        last_rdy[i] = cyc;
        rdy_cnt[i]++;
      end
      if (bus_err[i] === 1'b1) err_cnt[i]++;
    end
  endtask

  task automatic issue(input int i, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [15:0] sw);
    @(posedge clk); #1;
    cpu_mio[i] = 1'b1; mem_read[i] = rd; mem_write[i] = wr;
    addr_bus[i] = a; data_out[i] = d; sw_in[i] = sw;
    t_rd[i] = rd; t_wr[i] = wr; t_addr[i] = a; t_data[i] = d; t_sw[i] = sw;
    issue_cyc[i] = cyc;
    due[i] = cyc + 1 + wcyc(i);
    issued[i]++;
    @(posedge clk); #1;
    cpu_mio[i] = 1'b0;
    mem_read[i] = 1'($urandom);
    mem_write[i] = 1'($urandom);
    addr_bus[i] = $urandom;
    data_out[i] = $urandom;
  endtask

  task automatic do_txn(input int i, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [15:0] sw);
    issue(i, rd, wr, a, d, sw);
    for (int k = 0; k < 40 && issued[i] != done[i]; k++) @(posedge clk);
    check("txn_done", i, 32'(done[i]), 32'(issued[i]));
    #1;
  endtask

  initial begin
    int rc;
    logic [31:0] d1;
    logic [31:0] d2;
    int c1;
    int c2;

    for (int i = 0; i < 2; i++) begin
      cpu_mio[i] = 1'b0; mem_read[i] = 1'b0; mem_write[i] = 1'b0;
      addr_bus[i] = '0; data_out[i] = '0; sw_in[i] = '0;
      data_m[i] = '0; led_m[i] = '0;
      issued[i] = 0; done[i] = 0; due[i] = 0; issue_cyc[i] = 0;
      last_rdy[i] = 0; rdy_cnt[i] = 0; err_cnt[i] = 0;
      t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_addr[i] = '0; t_data[i] = '0; t_sw[i] = '0;
    end

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 0, {31'b0, mio_ready[0]}, 32'h0);
    check("rst_led",   0, {16'h0, led_out[0]}, 32'h0);
    check("rst_data",  0, data_in[0], 32'h0);

    // RAM write then read, WAIT_CYCLES=2
    do_txn(0, 1'b0, 1'b1, 32'h0000_0010, 32'h3C03_F000, 16'h0);
    check("wr_latency", 0, 32'(last_rdy[0] - issue_cyc[0]), 32'd3);
    do_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 16'h0);
    check("ram_readback", 0, data_in[0], 32'h3C03_F000);

    // IO
    do_txn(0, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 16'hA5A5);
    check("sw_read", 0, data_in[0], 32'h0000_A5A5);
    do_txn(0, 1'b0, 1'b1, 32'hE000_0000, 32'h1234_003F, 16'hA5A5);
    check("led_write", 0, {16'h0, led_out[0]}, 32'h0000_003F);
    check("wr_keeps_data", 0, data_in[0], 32'h0000_A5A5);

    // WAIT_CYCLES=0 and a both-ops request
    do_txn(1, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_2222, 16'h0);
    check("w0_latency", 1, 32'(last_rdy[1] - issue_cyc[1]), 32'd1);
    do_txn(1, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 16'h0);
    check("both_err_pulses", 1, 32'(err_cnt[1]), 32'd1);
    do_txn(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 16'h0);
    check("both_wrote", 1, data_in[1], 32'hCAFE_F00D);

    // Reset during WAIT aborts the write
    do_txn(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0102_0304, 16'h0);
    rc = rdy_cnt[0];
    issue(0, 1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_ready", 0, 32'(rdy_cnt[0]), 32'(rc));
    do_txn(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 16'h0);
    check("abort_prior", 0, data_in[0], 32'h0102_0304);

    // Cycle counter
    do_txn(0, 1'b1, 1'b0, 32'hF000_0004, 32'h0, 16'h0);
    d1 = data_in[0];
    c1 = issue_cyc[0];
    repeat (5) @(posedge clk);
    do_txn(0, 1'b1, 1'b0, 32'hF000_0004, 32'h0, 16'h0);
    d2 = data_in[0];
    c2 = issue_cyc[0];
`ifdef MIO_COUNTER_EN
    check("cnt_delta", 0, d2 - d1, 32'(c2 - c1));
`else
    check("cnt_off_first", 0, d1, 32'h0);
    check("cnt_off_second", 0, d2, 32'h0);
`endif

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int i;
      int op;
      int k;
      logic rd;
      logic wr;
      logic [31:0] a;
      i  = int'($urandom_range(1, 0));
      op = int'($urandom_range(9, 0));
      k  = int'($urandom_range(9, 0));
      rd = (op < 4) || (op == 9);
      wr = (op >= 4);
      case (k)
        6: a = 32'hF000_0000 | 32'($urandom_range(3, 0));
        7: a = 32'hF000_0004;
        8: a = 32'hE000_0000 | 32'($urandom_range(3, 0));
        9: a = ($urandom_range(1, 0) == 0) ? 32'hF000_0100 : 32'hE000_0008;
        default: a = (32'($urandom_range(13, 0)) << 28) | (32'($urandom_range(3, 0)) << 12)
                     | (32'($urandom_range(31, 0)) << 2) | 32'($urandom_range(3, 0));
      endcase
      if (k < 6 && !wr && !known[i][widx(a)]) begin
        rd = 1'b0;
        wr = 1'b1;
      end
      do_txn(i, rd, wr, a, $urandom, 16'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder on the far side of the multicycle controller's memory handshake. It accepts `MemRead`/`MemWrite` requests qualified by `CPU_MIO`, decodes the address to on-chip word RAM or memory-mapped IO, and inserts programmable wait states. It answers each request with a single-cycle `MIO_ready` pulse, plus read data where applicable. It sits between the CPU datapath and the board RAM/switch/LED resources.

## Interface
- `ADDR_W`, 10: RAM word-address width; RAM depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: wait states between request capture and `MIO_ready`; legal range 0–15.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `CPU_MIO`  in  1  CPU bus request qualifier.
- `MemRead`  in  1  read request.
- `MemWrite`  in  1  write request.
- `addr_bus`  in  32  byte address; bits [1:0] ignored.
- `Data_out`  in  32  write data from CPU.
- `Data_in`  out  32  read data to CPU.
- `MIO_ready`  out  1  transaction-complete strobe.
- `sw_in`  in  16  board switches.
- `led_out`  out  16  LED register.
- `bus_err`  out  1  one-cycle strobe: illegal request seen.

## Operation
- `req` = `CPU_MIO & (MemRead | MemWrite)`. If `MemRead` and `MemWrite` are both set, the access is treated as a write and `bus_err` pulses in the ACK cycle.
- FSM states:
  - IDLE: on `req`, latch the address, write data and op; load the wait counter with `WAIT_CYCLES`. Go to WAIT if `WAIT_CYCLES` > 0, else ACK.
  - WAIT: decrement the counter; go to ACK when it reaches 1.
  - ACK: `MIO_ready`=1; perform the write on the clock edge ending ACK; then IDLE.
- Address decode uses the latched address:
  - 0xF0000000: read returns {16'h0, `sw_in`}; write ignored.
  - 0xF0000004: read returns the free-running 32-bit cycle counter; write ignored.
  - 0xE0000000: read returns {16'h0, `led_out`}; write loads `led_out` from `Data_out[15:0]`.
  - Any other address with [31:28]=4'hF or 4'hE: read returns 0, write ignored.
  - All remaining addresses: RAM word `addr[ADDR_W+1:2]`; upper bits alias.
- Read path: `Data_in` is registered on entry to ACK and held until the next ACK of a read. A write ACK leaves `Data_in` unchanged.
- Inputs are not re-sampled during WAIT/ACK. Request changes mid-transaction are ignored.
- If `req` is still high in the IDLE cycle after ACK, a new transaction starts; the CPU is responsible for deasserting.
- The counter increments every cycle and wraps 0xFFFFFFFF→0.

## Timing
- With the request present in IDLE cycle N, `MIO_ready` is high in cycle N+1+`WAIT_CYCLES`, for exactly one cycle.
- Read data is valid in the same cycle as `MIO_ready`. Write data is visible to a read that captures at least one cycle after ACK.
- Reset values: state IDLE, `MIO_ready` 0, `Data_in` 0, `led_out` 0, `bus_err` 0, counter 0. RAM contents are not cleared.
- Reset mid-WAIT or mid-ACK: the transaction is aborted, no write commits, and the FSM is in IDLE on the next cycle.
- Reset has priority over `req` in the same cycle.

## Configuration
- `MIO_COUNTER_EN`:
  - Defined: the 32-bit cycle counter exists and is readable at 0xF0000004.
  - Undefined: the counter is not built, and reads of 0xF0000004 return 0.

## Test plan
- Reset with `WAIT_CYCLES`=2: assert `reset` 5 cycles. After release, `MIO_ready`=0, `led_out`=0, `Data_in`=0.
- RAM write then read:
  - Write 0x3C03F000 to 0x00000010, with `req` in cycle N → `MIO_ready` only in cycle N+3.
  - Then read 0x00000010 → `Data_in`=0x3C03F000 in its ready cycle.
- IO:
  - `sw_in`=0xA5A5, read 0xF0000000 → `Data_in`=0x0000A5A5.
  - Write 0x1234003F to 0xE0000000 → `led_out`=0x003F after ACK.
- `WAIT_CYCLES`=0: `req` in cycle N → `MIO_ready` in cycle N+1. Both-ops request → write performed and `bus_err` pulses with `MIO_ready`.
- Reset during WAIT of a write of 0xDEADBEEF to 0x20: no `MIO_ready`. A subsequent read of 0x20 returns the prior contents.
- Counter (`MIO_COUNTER_EN` defined): two reads of 0xF0000004 spaced K cycles apart differ by K. With the macro undefined, both return 0.
